uart_tx_interface: RTL and testbench



---
 rtl/uart_tx_interface_if.sv | 21 ++
 rtl/uart_tx_interface.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_interface.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_interface_if.sv
// System bus seen by the UART: one leader issues single-cycle read/write requests,
// the follower answers reads one cycle later with read_data_valid.
interface system_bus;
   logic [31:0] addr;
   logic        read_req;
   logic        write_req;
   logic [3:0]  byte_enable;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        read_data_valid;

   modport leader (
      output addr, read_req, write_req, byte_enable, write_data,
      input  read_data, read_data_valid
   );

   modport follower (
      input  addr, read_req, write_req, byte_enable, write_data,
      output read_data, read_data_valid
   );
endinterface

// File: rtl/uart_tx_interface.sv
// Memory-mapped 8N1 UART transmitter: TXDATA feeds a small FIFO, STATUS reports
// shifter/FIFO state, DIVISOR sets clocks per bit for the next frame.
module uart_tx_interface #(
   parameter int unsigned ClocksPerBit = 434,
   parameter int unsigned FifoDepth    = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   system_bus.follower bus,
   output logic       tx
);

   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned DivW = 16;
   localparam int unsigned BitW = 3;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // register decode
   logic [1:0] reg_sel;
   logic       push_req;
   logic       push;
   logic       pop_c;
   logic       full;
   logic       empty;
   logic       ovf_clr;

   assign reg_sel  = bus.addr[3:2];
   assign push_req = bus.write_req && (reg_sel == 2'd0) && bus.byte_enable[0];
   assign push     = push_req && !full;
   assign ovf_clr  = bus.write_req && (reg_sel == 2'd1) && bus.byte_enable[0] &&
                     bus.write_data[3];

   logic unused_bits;
   assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.write_data[31:16],
                          bus.byte_enable[3:2]};

   // transmit FIFO
   logic [7:0]      fifo_mem [FifoDepth];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic [CntW-1:0] count;

   assign full  = (count == CntW'(FifoDepth));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.write_data[7:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + PtrW'(1);
         if (pop_c) rd_ptr <= rd_ptr + PtrW'(1);
         unique case ({push, pop_c})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

   // control registers
   logic [DivW-1:0] div_q;
   logic            overflow;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q    <= DivW'(ClocksPerBit);
         overflow <= 1'b0;
      end else begin
         if (bus.write_req && (reg_sel == 2'd2)) begin
            if (bus.byte_enable[0]) div_q[7:0]  <= bus.write_data[7:0];
            if (bus.byte_enable[1]) div_q[15:8] <= bus.write_data[15:8];
         end
         if (push_req && full) overflow <= 1'b1;
         else if (ovf_clr)     overflow <= 1'b0;
      end
   end

   // transmit FSM
   state_t          state_q, state_d;
   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic [DivW-1:0] div_lat_q, div_lat_d;
   logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_d;
   logic            last_tick;
   logic            busy;

   assign last_tick = (div_cnt_q == div_lat_q - DivW'(1));
   assign busy      = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         div_cnt_q <= '0;
         div_lat_q <= DivW'(1);
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx        <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         div_lat_q <= div_lat_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx        <= tx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      div_lat_d = div_lat_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      pop_c     = 1'b0;
      tx_d      = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop_c     = 1'b1;
               shift_d   = fifo_mem[rd_ptr];
               div_lat_d = (div_q == '0) ? DivW'(1) : div_q;
               div_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (last_tick) begin
               div_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = S_DATA;
            end else begin
               div_cnt_d = div_cnt_q + DivW'(1);
            end
         end
         S_DATA: begin
            if (last_tick) begin
               div_cnt_d = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == BitW'(7)) begin
                  bit_cnt_d = '0;
                  state_d   = S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BitW'(1);
               end
            end else begin
               div_cnt_d = div_cnt_q + DivW'(1);
            end
         end
         S_STOP: begin
            if (last_tick) begin
               div_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               div_cnt_d = div_cnt_q + DivW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // line level follows the state being entered so tx stays registered
      if (state_d == S_START)     tx_d = 1'b0;
      else if (state_d == S_DATA) tx_d = shift_d[0];
   end

   // read path returns pre-write values
   logic [31:0] rdata_c;

   always_comb begin
      rdata_c = '0;
      unique case (reg_sel)
         2'd1: begin
            rdata_c[0]    = busy;
            rdata_c[1]    = full;
            rdata_c[2]    = empty;
            rdata_c[3]    = overflow;
            rdata_c[11:8] = 4'(count);
         end
         2'd2:    rdata_c[15:0] = div_q;
         default: rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.read_data       <= '0;
         bus.read_data_valid <= 1'b0;
      end else begin
         bus.read_data_valid <= bus.read_req;
         if (bus.read_req) bus.read_data <= rdata_c;
      end
   end

endmodule

// File: tb/tb_uart_tx_interface.sv
// Scoreboard bench for uart_tx_interface: expected reads and frames are queued by
// the stimulus and checked by a negedge monitor as the DUT produces them.
module tb_uart_tx_interface;

   typedef struct {
      logic [7:0]  data;
      int unsigned div;
   } frame_t;

   logic clk = 1'b0;
   logic reset_n;
   logic tx;

   system_bus bus ();

   uart_tx_interface #(.ClocksPerBit(434), .FifoDepth(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .tx      (tx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_reads [$];
   frame_t      exp_frames [$];

   task automatic check(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor state
   bit          req_hist = 1'b0;
   bit          prev_tx  = 1'b1;
   int          mstate   = 0;
   int          ph, cyc;
   bit          bad;
   bit          exp_bit;
   frame_t      cur;

   always @(negedge clk) begin
      if (!reset_n) begin
         req_hist = 1'b0;
         mstate   = 0;
         prev_tx  = 1'b1;
      end else begin
         // read responses: valid exactly one cycle after request
         if (bus.read_data_valid || req_hist)
            check(bus.read_data_valid == req_hist, "read_valid_timing",
                  32'(bus.read_data_valid), 32'(req_hist));
         if (bus.read_data_valid) begin
            check(exp_reads.size() != 0, "read_unexpected", bus.read_data, 32'd0);
            if (exp_reads.size() != 0) begin
               logic [31:0] e;
               e = exp_reads.pop_front();
               check(bus.read_data === e, "read_data", bus.read_data, e);
            end
         end
         req_hist = bus.read_req;

         // serial frame decode
         if (mstate == 0 && tx == 1'b0 && prev_tx == 1'b1) begin
            check(exp_frames.size() != 0, "frame_unexpected", 32'(tx), 32'd1);
            if (exp_frames.size() != 0) begin
               cur    = exp_frames.pop_front();
               mstate = 1;
               ph     = 0;
               cyc    = 0;
               bad    = 1'b0;
            end
         end
         if (mstate == 1) begin
            if (ph == 0)      exp_bit = 1'b0;
            else if (ph == 9) exp_bit = 1'b1;
            else              exp_bit = cur.data[ph-1];
            if (tx !== exp_bit) bad = 1'b1;
            cyc++;
            if (cyc == int'(cur.div)) begin
               check(!bad, $sformatf("frame_%02h_bit%0d", cur.data, ph),
                     32'(bad ? ~exp_bit : exp_bit), 32'(exp_bit));
               bad = 1'b0;
               cyc = 0;
               ph++;
               if (ph == 10) mstate = 0;
            end
         end
         prev_tx = tx;
      end
   end

   // each task starts and ends 1 time unit after a rising edge
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be);
      bus.addr = addr; bus.write_data = data; bus.byte_enable = be; bus.write_req = 1'b1;
      @(posedge clk); #1;
      bus.write_req = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
      bus.addr = addr; bus.read_req = 1'b1;
      exp_reads.push_back(exp);
      @(posedge clk); #1;
      bus.read_req = 1'b0;
   endtask

   task automatic bus_rw(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic [31:0] exp);
      bus.addr = addr; bus.write_data = data; bus.byte_enable = be;
      bus.write_req = 1'b1; bus.read_req = 1'b1;
      exp_reads.push_back(exp);
      @(posedge clk); #1;
      bus.write_req = 1'b0; bus.read_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int unsigned div);
      frame_t f;
      f.data = b; f.div = div;
      exp_frames.push_back(f);
      bus_write(32'h0, {24'h0, b}, 4'b0001);
   endtask

   task automatic wait_drain(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         if (exp_frames.size() == 0 && mstate == 0) break;
         @(posedge clk); #1;
      end
      check(i < budget, "drain_timeout", 32'(exp_frames.size()), 32'd0);
      idle(3);
   endtask

   initial begin
      reset_n = 1'b0;
      bus.addr = '0; bus.read_req = 1'b0; bus.write_req = 1'b0;
      bus.byte_enable = '0; bus.write_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check(tx === 1'b1, "reset_tx", 32'(tx), 32'd1);
      check(bus.read_data_valid === 1'b0, "reset_rvalid", 32'(bus.read_data_valid), 32'd0);
      check(bus.read_data === 32'h0, "reset_rdata", bus.read_data, 32'h0);
      reset_n = 1'b1;
      idle(2);

      // reset register values
      bus_read(32'h4, 32'h0000_0004);
      bus_read(32'h8, 32'd434);
      bus_read(32'hC, 32'h0);
      bus_read(32'h0, 32'h0);
      idle(2);

      // single frame at 4 clocks per bit, busy sampled mid-frame
      bus_write(32'h8, 32'd4, 4'b0011);
      send(8'h55, 4);
      idle(1);
      bus_read(32'h4, 32'h0000_0005);
      idle(30);
      bus_read(32'h4, 32'h0000_0005);
      wait_drain(200);
      bus_read(32'h4, 32'h0000_0004);
      idle(2);

      // FIFO fill, overflow and sticky clear
      bus_write(32'h8, 32'd2, 4'b0011);
      for (int i = 1; i <= 5; i++) send(8'(i), 2);
      bus_read(32'h4, 32'h0000_0403);
      bus_write(32'h0, 32'h06, 4'b0001);
      bus_read(32'h4, 32'h0000_040B);
      wait_drain(1000);
      bus_read(32'h4, 32'h0000_000C);
      bus_write(32'h4, 32'h8, 4'b0001);
      bus_read(32'h4, 32'h0000_0004);
      idle(2);

      // divisor change mid-frame only applies to the next frame
      bus_write(32'h8, 32'd3, 4'b0011);
      send(8'hA0, 3);
      idle(6);
      bus_write(32'h8, 32'd8, 4'b0011);
      send(8'hFF, 8);
      wait_drain(1000);
      bus_read(32'h8, 32'd8);
      idle(2);

      // same-cycle read/write and byte-lane writes
      bus_write(32'h8, 32'd5, 4'b0011);
      bus_rw(32'h8, 32'd9, 4'b0011, 32'd5);
      bus_read(32'h8, 32'd9);
      bus_write(32'h8, 32'h0000_1200, 4'b0010);
      bus_read(32'h8, 32'h0000_1209);
      idle(2);

      // asynchronous reset in the middle of a frame
      bus_write(32'h8, 32'd4, 4'b0011);
      send(8'h00, 4);
      bus_write(32'h0, 32'h11, 4'b0001);
      bus_write(32'h0, 32'h22, 4'b0001);
      idle(8);
      check(tx === 1'b0, "pre_reset_tx_low", 32'(tx), 32'd0);
      reset_n = 1'b0;
      #1;
      check(tx === 1'b1, "async_reset_tx", 32'(tx), 32'd1);
      exp_frames.delete();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(2);
      bus_read(32'h4, 32'h0000_0004);
      bus_read(32'h8, 32'd434);
      idle(200);
      check(tx === 1'b1, "post_reset_idle_tx", 32'(tx), 32'd1);

      check(exp_frames.size() == 0, "frames_pending", 32'(exp_frames.size()), 32'd0);
      check(exp_reads.size() == 0, "reads_pending", 32'(exp_reads.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
